// File: rtl/mxrv_csr_ctrl_if.sv
// Signal bundle between the CSR access controller, the execute stage that feeds it
// and the CSR register file it drives. The "master" modport is the controller's view.
interface mxrv_csr_ctrl_if #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
);
    // Handshake: an instruction transfers on a clk edge where req_valid_i && req_ready_o;
    // the requester holds req_valid_i and its payload stable until that edge.
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [31:0]           inst_i;
    logic [XLEN-1:0]       rs1_data_i;
    logic [CSR_ADDR_W-1:0] csr_addr_o;
    logic                  csr_we_o;
    logic [XLEN-1:0]       csr_wdata_o;
    logic [XLEN-1:0]       csr_rdata_i;
    logic                  rd_we_o;
    logic [4:0]            rd_addr_o;
    logic [XLEN-1:0]       rd_wdata_o;
    logic                  done_o;
    logic                  illegal_o;

    modport master (
        input  req_valid_i, inst_i, rs1_data_i, csr_rdata_i,
        output req_ready_o, csr_addr_o, csr_we_o, csr_wdata_o,
               rd_we_o, rd_addr_o, rd_wdata_o, done_o, illegal_o
    );

    modport slave (
        output req_valid_i, inst_i, rs1_data_i, csr_rdata_i,
        input  req_ready_o, csr_addr_o, csr_we_o, csr_wdata_o,
               rd_we_o, rd_addr_o, rd_wdata_o, done_o, illegal_o
    );
endinterface

// File: rtl/mxrv_csr_ctrl.sv
// CSR read-modify-write sequencer: accepts one CSRRx instruction, reads the CSR,
// optionally writes the merged value back and returns the old value to rd.
module mxrv_csr_ctrl #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12,
    parameter bit RO_CHECK   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mxrv_csr_ctrl_if.master   bus,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic            live_q;
    logic [4:0]      rd_q;
    logic [11:0]     csr_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] src_q;
    logic            wr_en_q;
    logic            illegal_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] new_q;

    logic            accept;
    logic [2:0]      funct3;
    logic            legal_op;
    logic            dec_wr_en;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_src;
    logic [XLEN-1:0] new_val;

    assign funct3      = bus.inst_i[14:12];
    assign legal_op    = (bus.inst_i[6:0] == 7'b1110011) && (funct3[1:0] != 2'b00);
    assign dec_src     = funct3[2] ? {{(XLEN-5){1'b0}}, bus.inst_i[19:15]} : bus.rs1_data_i;
    // Set/clear forms with a zero source field are pure reads and never write.
    assign dec_wr_en   = (funct3[1:0] == 2'b01) || (bus.inst_i[19:15] != 5'd0);
    assign dec_illegal = !legal_op ||
                         (RO_CHECK && dec_wr_en && (bus.inst_i[31:30] == 2'b11));

    always_comb begin
        new_val = '0;
        case (op_q)
            2'b01:   new_val = src_q;
            2'b10:   new_val = bus.csr_rdata_i | src_q;
            default: new_val = bus.csr_rdata_i & ~src_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // live_q keeps ready low through the reset cycle itself and for the edge that samples rst low.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q    <= 1'b0;
            rd_q      <= '0;
            csr_q     <= '0;
            op_q      <= '0;
            src_q     <= '0;
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            old_q     <= '0;
            new_q     <= '0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                rd_q      <= bus.inst_i[11:7];
                csr_q     <= bus.inst_i[31:20];
                op_q      <= funct3[1:0];
                src_q     <= dec_src;
                wr_en_q   <= dec_wr_en;
                illegal_q <= dec_illegal;
                old_q     <= '0;
                new_q     <= '0;
            end
            if (state_q == CAP) begin
                old_q <= bus.csr_rdata_i;
                new_q <= new_val;
            end
        end
    end

    assign accept = (state_q == IDLE) && live_q && bus.req_valid_i;

    always_comb begin
        state_d         = state_q;
        bus.req_ready_o = 1'b0;
        bus.csr_addr_o  = '0;
        bus.csr_we_o    = 1'b0;
        bus.csr_wdata_o = '0;
        bus.rd_we_o     = 1'b0;
        bus.rd_addr_o   = '0;
        bus.rd_wdata_o  = '0;
        bus.done_o      = 1'b0;
        bus.illegal_o   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready_o = live_q;
                if (accept) begin
                    state_d = dec_illegal ? RESP : RD;
                end
            end
            RD: begin
                bus.csr_addr_o = CSR_ADDR_W'(csr_q);
                state_d        = CAP;
            end
            CAP: begin
                bus.csr_addr_o = CSR_ADDR_W'(csr_q);
                state_d        = wr_en_q ? WR : RESP;
            end
            WR: begin
                bus.csr_addr_o  = CSR_ADDR_W'(csr_q);
                bus.csr_we_o    = 1'b1;
                bus.csr_wdata_o = new_q;
                state_d         = RESP;
            end
            RESP: begin
                bus.done_o     = 1'b1;
                bus.rd_we_o    = (rd_q != 5'd0) && !illegal_q;
                bus.rd_addr_o  = rd_q;
                bus.rd_wdata_o = old_q;
                bus.illegal_o  = illegal_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_dbg = state_q;

endmodule
